// File: rtl/fft16_ctrl.sv
// Sequencer for a 16-point radix-2 DIF FFT around a single shared butterfly PE.
// Buffers one frame, issues 4x8 butterflies with in-place write-back, streams X(k) in natural order.
module fft16_ctrl #(
    parameter int unsigned DW         = 32,
    parameter int unsigned PE_TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic [DW-1:0] pe_a,
    output logic [DW-1:0] pe_b,
    output logic [2:0]    pe_power,
    output logic          pe_ab_valid,
    input  logic [DW-1:0] pe_fft_a,
    input  logic [DW-1:0] pe_fft_b,
    input  logic          pe_valid,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [3:0]    out_index,
    output logic          busy,
    output logic          err
);

    localparam int unsigned WW = (PE_TIMEOUT < 2) ? 1 : $clog2(PE_TIMEOUT);
    localparam logic [WW-1:0] WAIT_LAST = WW'(PE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        LOAD,
        ISSUE,
        WAIT,
        OUT
    } state_t;

    state_t          state_q;
    logic [DW-1:0]   mem_q [16];
    logic [3:0]      cnt_q;
    logic [1:0]      s_q;
    logic [2:0]      k_q;
    logic [WW-1:0]   wcnt_q;
    logic            pv_q;
    logic [DW-1:0]   pe_a_q, pe_b_q, out_data_q;
    logic [2:0]      pe_power_q;
    logic            pe_ab_valid_q, out_valid_q, in_ready_q, busy_q, err_q;
    logic [3:0]      out_index_q;

    logic [3:0]      span, jj, gg, ia, ib, pw4;
    logic [2:0]      power_d;
    logic            capture;

    function automatic logic [3:0] bitrev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    // Butterfly addressing: span halves each stage, k splits into group g and offset j.
    always_comb begin
        span    = 4'd8 >> s_q;
        jj      = {1'b0, k_q} & (span - 4'd1);
        gg      = {1'b0, k_q} >> (2'd3 - s_q);
        ia      = (gg << (3'd4 - {1'b0, s_q})) | jj;
        ib      = ia + span;
        pw4     = jj << s_q;
        power_d = pw4[2:0];
    end

    // Only a fresh rising edge of pe_valid is a result; a held level is stale.
    assign capture = pe_valid & ~pv_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= LOAD;
            mem_q         <= '{default: '0};
            cnt_q         <= '0;
            s_q           <= '0;
            k_q           <= '0;
            wcnt_q        <= '0;
            pv_q          <= 1'b0;
            pe_a_q        <= '0;
            pe_b_q        <= '0;
            pe_power_q    <= '0;
            pe_ab_valid_q <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_index_q   <= '0;
            in_ready_q    <= 1'b1;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            pv_q          <= pe_valid;
            pe_ab_valid_q <= 1'b0;
            out_valid_q   <= 1'b0;
            case (state_q)
                LOAD: begin
                    if (in_valid) begin
                        mem_q[cnt_q] <= in_data;
                        cnt_q        <= cnt_q + 4'd1;
                        if (cnt_q == 4'd15) begin
                            state_q    <= ISSUE;
                            s_q        <= '0;
                            k_q        <= '0;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    pe_a_q        <= mem_q[ia];
                    pe_b_q        <= mem_q[ib];
                    pe_power_q    <= power_d;
                    pe_ab_valid_q <= 1'b1;
                    wcnt_q        <= '0;
                    state_q       <= WAIT;
                end
                WAIT: begin
                    if (capture) begin
                        mem_q[ia] <= pe_fft_a;
                        mem_q[ib] <= pe_fft_b;
                        if (k_q != 3'd7) begin
                            k_q     <= k_q + 3'd1;
                            state_q <= ISSUE;
                        end else if (s_q != 2'd3) begin
                            s_q     <= s_q + 2'd1;
                            k_q     <= '0;
                            state_q <= ISSUE;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= OUT;
                        end
                    end else if (wcnt_q == WAIT_LAST) begin
                        err_q      <= 1'b1;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= LOAD;
                    end else begin
                        wcnt_q <= wcnt_q + 1'b1;
                    end
                end
                OUT: begin
                    out_valid_q <= 1'b1;
                    out_index_q <= cnt_q;
                    out_data_q  <= mem_q[bitrev4(cnt_q)];
                    cnt_q       <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= LOAD;
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign pe_a        = pe_a_q;
    assign pe_b        = pe_b_q;
    assign pe_power    = pe_power_q;
    assign pe_ab_valid = pe_ab_valid_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_index   = out_index_q;
    assign busy        = busy_q;
    assign err         = err_q;

endmodule

// File: tb/tb_fft16_ctrl.sv
// Directed bench for fft16_ctrl with a behavioural butterfly PE (butterfly, pass-through or hung).
// Frame cases are table-driven; timeout and mid-run reset are hand-written sequences.
module tb_fft16_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic [31:0] pe_a, pe_b;
    logic [2:0]  pe_power;
    logic        pe_ab_valid;
    logic [31:0] pe_fft_a = '0, pe_fft_b = '0;
    logic        pe_valid = 1'b0;
    logic        out_valid;
    logic [31:0] out_data;
    logic [3:0]  out_index;
    logic        busy, err;

    always #5 clk = ~clk;

    fft16_ctrl #(.DW(32), .PE_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .pe_a(pe_a), .pe_b(pe_b), .pe_power(pe_power), .pe_ab_valid(pe_ab_valid),
        .pe_fft_a(pe_fft_a), .pe_fft_b(pe_fft_b), .pe_valid(pe_valid),
        .out_valid(out_valid), .out_data(out_data), .out_index(out_index),
        .busy(busy), .err(err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_tol(input string name, input logic [31:0] act, input logic [31:0] exp, input int tol);
        int dr, di;
        dr = int'($signed(act[31:16])) - int'($signed(exp[31:16]));
        di = int'($signed(act[15:0])) - int'($signed(exp[15:0]));
        n_cmp++;
        if (dr > tol || dr < -tol || di > tol || di < -tol || $isunknown(act)) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (+/-%0d)", name, act, exp, tol);
        end
    endtask

    // ---------------- behavioural PE ----------------
    int pe_mode = 0;   // 0 butterfly, 1 pass-through, 2 never answers
    int pe_hold = 1;   // cycles pe_valid stays high per result
    int dly = 0, hcnt = 0;
    logic [31:0] res_a, res_b;

    function automatic logic [31:0] bfly_b(input logic [31:0] a, input logic [31:0] b, input logic [2:0] p);
        int dr, di, wr, wi, yr, yi;
        dr = int'($signed(a[31:16])) - int'($signed(b[31:16]));
        di = int'($signed(a[15:0])) - int'($signed(b[15:0]));
        case (p)
            3'd0: begin wr =  16384; wi =      0; end
            3'd1: begin wr =  15137; wi =  -6270; end
            3'd2: begin wr =  11585; wi = -11585; end
            3'd3: begin wr =   6270; wi = -15137; end
            3'd4: begin wr =      0; wi = -16384; end
            3'd5: begin wr =  -6270; wi = -15137; end
            3'd6: begin wr = -11585; wi = -11585; end
            default: begin wr = -15137; wi = -6270; end
        endcase
        yr = (dr * wr - di * wi) >>> 14;
        yi = (dr * wi + di * wr) >>> 14;
        return {yr[15:0], yi[15:0]};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            dly = 0; hcnt = 0; pe_valid = 1'b0; pe_fft_a = '0; pe_fft_b = '0;
        end else begin
            if (pe_ab_valid && pe_mode != 2) begin
                if (pe_mode == 1) begin
                    res_a = pe_a; res_b = pe_b;
                end else begin
                    res_a = {pe_a[31:16] + pe_b[31:16], pe_a[15:0] + pe_b[15:0]};
                    res_b = bfly_b(pe_a, pe_b, pe_power);
                end
                dly = 4;
            end
            if (dly > 0) begin
                dly--;
                if (dly == 0) begin
                    hcnt = pe_hold; pe_fft_a = res_a; pe_fft_b = res_b;
                end
            end
            if (hcnt > 0) begin pe_valid = 1'b1; hcnt--; end
            else pe_valid = 1'b0;
        end
    end

    // ---------------- issue log ----------------
    typedef struct packed { logic [31:0] a; logic [31:0] b; logic [2:0] p; } issue_t;
    issue_t issue_log [512];
    int issue_total = 0;
    always @(negedge clk) if (pe_ab_valid) begin
        issue_log[issue_total & 511] = '{a: pe_a, b: pe_b, p: pe_power};
        issue_total++;
    end

    // Hand-derived butterfly order: {ia, ib, power}
    typedef struct { int ia; int ib; int pw; } bf_t;
    bf_t bf_tab [32] = '{
        '{0,8,0}, '{1,9,1}, '{2,10,2}, '{3,11,3}, '{4,12,4}, '{5,13,5}, '{6,14,6}, '{7,15,7},
        '{0,4,0}, '{1,5,2}, '{2,6,4},  '{3,7,6},  '{8,12,0}, '{9,13,2}, '{10,14,4},'{11,15,6},
        '{0,2,0}, '{1,3,4}, '{4,6,0},  '{5,7,4},  '{8,10,0}, '{9,11,4}, '{12,14,0},'{13,15,4},
        '{0,1,0}, '{2,3,0}, '{4,5,0},  '{6,7,0},  '{8,9,0},  '{10,11,0},'{12,13,0},'{14,15,0}
    };
    int brev_tab [16] = '{0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15};

    logic [31:0] frame_in [16];
    logic [31:0] exp_out  [16];

    // pat 0: DC 1.0, pat 1: impulse, pat 2: ramp re=n (used with pass-through PE)
    task automatic set_pattern(input int pat);
        for (int n = 0; n < 16; n++) begin
            case (pat)
                0: begin
                    frame_in[n] = 32'h0100_0000;
                    exp_out[n]  = (n == 0) ? 32'h1000_0000 : 32'h0;
                end
                1: begin
                    frame_in[n] = (n == 0) ? 32'h0100_0000 : 32'h0;
                    exp_out[n]  = 32'h0100_0000;
                end
                default: begin
                    frame_in[n] = {16'(n), 16'h0};
                    exp_out[n]  = {16'(brev_tab[n]), 16'h0};
                end
            endcase
        end
    endtask

    task automatic load_frame();
        chk("in_ready_before_load", in_ready, 1);
        for (int n = 0; n < 16; n++) begin
            in_valid = 1'b1; in_data = frame_in[n];
            @(negedge clk);
        end
        in_valid = 1'b0; in_data = '0;
        chk("in_ready_after_16th", in_ready, 0);
        chk("busy_after_load", busy, 1);
    endtask

    task automatic collect_and_check(input string tag, input int tol, input bit poke);
        int c;
        c = 0;
        while (!out_valid && c < 3000) begin @(negedge clk); c++; end
        if (!out_valid) begin
            chk({tag, "_out_timeout"}, 0, 1);
            return;
        end
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("%s_valid%0d", tag, i), out_valid, 1);
            chk($sformatf("%s_index%0d", tag, i), out_index, i);
            chk_tol($sformatf("%s_X%0d", tag, i), out_data, exp_out[i], tol);
            in_valid = poke && (i < 15);
            in_data  = poke ? 32'hDEAD_BEEF : 32'h0;
            @(negedge clk);
        end
        in_valid = 1'b0; in_data = '0;
        chk({tag, "_out_len"}, out_valid, 0);
        chk({tag, "_busy_done"}, busy, 0);
        chk({tag, "_in_ready_done"}, in_ready, 1);
    endtask

    typedef struct { string name; int mode; int hold; int pat; int tol; bit poke; bit chk_order; } fcase_t;
    fcase_t cases [4] = '{
        '{"dc",      0, 1, 0, 0, 1'b0, 1'b0},
        '{"order",   1, 1, 2, 0, 1'b0, 1'b1},
        '{"impulse", 0, 1, 1, 2, 1'b0, 1'b0},
        '{"stale",   0, 3, 0, 0, 1'b0, 1'b0}
    };

    task automatic run_case(input fcase_t fc);
        int base;
        pe_mode = fc.mode; pe_hold = fc.hold;
        set_pattern(fc.pat);
        base = issue_total;
        load_frame();
        collect_and_check(fc.name, fc.tol, fc.poke);
        chk({fc.name, "_issue_count"}, issue_total - base, 32);
        if (fc.chk_order) begin
            for (int i = 0; i < 32; i++) begin
                issue_t r;
                r = issue_log[(base + i) & 511];
                chk($sformatf("order_a%0d", i), r.a, {16'(bf_tab[i].ia), 16'h0});
                chk($sformatf("order_b%0d", i), r.b, {16'(bf_tab[i].ib), 16'h0});
                chk($sformatf("order_pw%0d", i), r.p, bf_tab[i].pw);
            end
        end
    endtask

    initial begin
        int c;
        bit seen_out;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_ab_valid", pe_ab_valid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_pe_a", pe_a, 0);
        rst = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 4; t++) run_case(cases[t]);

        // Hung PE: err after exactly PE_TIMEOUT cycles of WAIT, no output, back to LOAD.
        pe_mode = 2; pe_hold = 1;
        set_pattern(0);
        load_frame();
        seen_out = 1'b0;
        c = 0;
        while (!pe_ab_valid && c < 50) begin @(negedge clk); c++; end
        chk("hung_issue_seen", pe_ab_valid, 1);
        c = 0;
        while (!err && c < 100) begin
            @(negedge clk); c++;
            if (out_valid) seen_out = 1'b1;
        end
        chk("hung_err", err, 1);
        chk("hung_wait_cycles", c, 15);
        @(negedge clk);
        chk("hung_in_ready", in_ready, 1);
        chk("hung_busy", busy, 0);
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen_out = 1'b1;
        end
        chk("hung_no_output", seen_out, 0);
        chk("hung_err_sticky", err, 1);

        rst = 1'b0;
        @(negedge clk);
        chk("rst_clears_err", err, 0);
        rst = 1'b1;
        @(negedge clk);

        // Reset during stage-2 WAIT, then a clean frame with in_valid pokes during OUT.
        pe_mode = 0; pe_hold = 1;
        set_pattern(0);
        c = issue_total;
        load_frame();
        begin
            int w;
            w = 0;
            while (issue_total - c < 17 && w < 2000) begin @(posedge clk); w++; end
        end
        chk("mid_reached_stage2", (issue_total - c >= 17), 1);
        chk("mid_pe_a_nonzero", (pe_a != 0), 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pe_a", pe_a, 0);
        chk("mid_rst_pe_b", pe_b, 0);
        chk("mid_rst_ab_valid", pe_ab_valid, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        pe_mode = 0; pe_hold = 1;
        set_pattern(0);
        load_frame();
        collect_and_check("after_rst_dc", 0, 1'b1);
        run_case(cases[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
